// File: rtl/stopwatch_core_pkg.sv
// Shared types, 7-segment code constants and decode helper for the stopwatch core.
package stopwatch_core_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Scan index: which display digit is currently being driven.
    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_idx_t;

    // Segment codes, active-high, bit order {dp,g,f,e,d,c,b,a}; dp always off.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high anode pattern with every digit dark.
    localparam logic [3:0] ANODE_OFF = 4'b0000;

    function automatic logic [7:0] seg7_decode(input bcd_digit_t d);
        logic [7:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] anode_onehot(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Strobe/control inputs and display/status outputs of the stopwatch core.
interface stopwatch_core_if;

    logic        tick_1hz;
    logic        tick_2hz;
    logic        tick_scan;
    logic        tick_blink;
    logic        pause_pulse;
    logic        adj;
    logic        sel;
    logic [15:0] time_bcd;
    logic        paused;
    logic [7:0]  seg;
    logic [3:0]  an;

    modport master (
        output tick_1hz, tick_2hz, tick_scan, tick_blink, pause_pulse, adj, sel,
        input  time_bcd, paused, seg, an
    );

    modport slave (
        input  tick_1hz, tick_2hz, tick_scan, tick_blink, pause_pulse, adj, sel,
        output time_bcd, paused, seg, an
    );

endinterface

// File: rtl/stopwatch_core_bcd_mod_counter.sv
// Two-digit BCD modulo counter: wraps to 00 after WRAP_VAL, flags the wrap as carry.
module bcd_mod_counter
    import stopwatch_core_pkg::*;
#(
    parameter logic [7:0] WRAP_VAL = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    output logic [7:0] count_o,
    output logic       carry_o
);

    bcd_digit_t ones_q, ones_d;
    bcd_digit_t tens_q, tens_d;
    logic       at_wrap;

    assign at_wrap = ({tens_q, ones_q} == WRAP_VAL);
    assign carry_o = inc_i && at_wrap;
    assign count_o = {tens_q, ones_q};

    // Next count: wrap on the full two-digit field, otherwise BCD increment.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc_i) begin
            if (at_wrap) begin
                ones_d = '0;
                tens_d = '0;
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with field adjust/blink and multiplexed 4-digit 7-seg drive.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter logic [7:0] MIN_WRAP       = 8'h59,
    parameter logic [7:0] SEC_WRAP       = 8'h59,
    parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_core_if.slave  sw
);

    localparam logic [3:0] AN_RESET  = SEG_ACTIVE_LOW ? ~ANODE_OFF : ANODE_OFF;
    localparam logic [7:0] SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic       paused_q, paused_d;
    logic       blink_q, blink_d;
    logic       disp_en_q, disp_en_d;
    digit_idx_t idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [7:0] seg_q, seg_d;

    logic       run;
    logic       sec_inc, min_inc, sec_carry, min_carry;
    logic [7:0] sec_bcd, min_bcd;

    logic       field_hit;
    logic       lit;
    bcd_digit_t digit;
    logic [3:0] an_act;
    logic [7:0] seg_act;

    // Adjust steps one field only, so the seconds carry is used solely when running.
    always_comb begin
        run     = !sw.adj && !paused_q;
        sec_inc = run ? sw.tick_1hz : (sw.adj && sw.sel && sw.tick_2hz);
        min_inc = run ? (sw.tick_1hz && sec_carry) : (sw.adj && !sw.sel && sw.tick_2hz);
    end

    bcd_mod_counter #(.WRAP_VAL(SEC_WRAP)) u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (sec_inc),
        .count_o (sec_bcd),
        .carry_o (sec_carry)
    );

    bcd_mod_counter #(.WRAP_VAL(MIN_WRAP)) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (min_inc),
        .count_o (min_bcd),
        .carry_o (min_carry)
    );

    // Pause toggle, blink phase, scan index and display-enable next state.
    always_comb begin
        paused_d  = sw.pause_pulse ? !paused_q : paused_q;
        blink_d   = !sw.adj ? 1'b1 : (sw.tick_blink ? !blink_q : blink_q);
        idx_d     = sw.tick_scan ? digit_idx_t'(idx_q + 2'd1) : idx_q;
        disp_en_d = disp_en_q || sw.tick_scan;
    end

    // Display mux: digits stay dark until the first scan strobe after reset.
    always_comb begin
        case (idx_d)
            DIG_SEC_ONES: digit = sec_bcd[3:0];
            DIG_SEC_TENS: digit = sec_bcd[7:4];
            DIG_MIN_ONES: digit = min_bcd[3:0];
            default:      digit = min_bcd[7:4];
        endcase
        field_hit = sw.sel ? (idx_d == DIG_SEC_ONES || idx_d == DIG_SEC_TENS)
                           : (idx_d == DIG_MIN_ONES || idx_d == DIG_MIN_TENS);
        lit     = disp_en_d && !(sw.adj && !blink_d && field_hit);
        an_act  = lit ? anode_onehot(idx_d) : ANODE_OFF;
        seg_act = lit ? seg7_decode(digit) : SEG_BLANK;
        an_d    = SEG_ACTIVE_LOW ? ~an_act : an_act;
        seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paused_q  <= 1'b0;
            blink_q   <= 1'b1;
            disp_en_q <= 1'b0;
            idx_q     <= DIG_SEC_ONES;
            an_q      <= AN_RESET;
            seg_q     <= SEG_RESET;
        end else begin
            paused_q  <= paused_d;
            blink_q   <= blink_d;
            disp_en_q <= disp_en_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign sw.time_bcd = {min_bcd, sec_bcd};
    assign sw.paused   = paused_q;
    assign sw.an       = an_q;
    assign sw.seg      = seg_q;

    // Minutes wrap needs no further action; the carry is observed only for completeness.
    logic unused_min_carry;
    assign unused_min_carry = min_carry;

endmodule
